// File: rtl/urv_timer_sched_if.sv
// urv_timer_sched_if -- register access bus for the timer scheduler.
//   req   : access strobe, one access per high cycle
//   we    : 1 = write, 0 = read (qualified by req)
//   addr  : word address
//   wdata : write data
//   ack   : acknowledge, one cycle after each req cycle
//   rdata : read data, valid with ack, 0 otherwise
interface urv_timer_sched_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/urv_timer_sched.sv
// urv_timer_sched -- multi-channel one-shot/periodic tick timer with a
// small register file and a fixed-priority interrupt output.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   sys_tick_i   : one-cycle tick strobe, counted by every armed channel
//   bus          : register access (urv_timer_sched_if.slave)
//   pending_o    : per-channel pending flags (unimplemented channels 0)
//   irq_o        : OR of pending & mask
//   irq_id_o     : lowest channel with pending & mask, 0 when none

// urv_timer_chan -- one timer channel: IDLE/ARMED FSM, 24-bit down-counter,
// programmed delay, periodic flag and sticky pending/overrun flags.
module urv_timer_chan (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        dly_we_i,
  input  logic        ctrl_we_i,
  input  logic [23:0] wdata_i,
  input  logic        clr_pend_i,
  input  logic        clr_ovr_i,
  output logic [23:0] dly_o,
  output logic        armed_o,
  output logic        periodic_o,
  output logic        pend_o,
  output logic        ovr_o
);
  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d, dly_q, load;
  logic        per_q, per_d, pend_q, ovr_q, fire;

  // A zero delay behaves as one tick.
  assign load = (dly_q == 24'd0) ? 24'd1 : dly_q;

  // A CTRL write takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    fire    = 1'b0;
    if (ctrl_we_i) begin
      per_d = wdata_i[1];
      if (wdata_i[0]) begin
        state_d = S_ARMED;
        cnt_d   = load;
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_ARMED && tick_i) begin
      if (cnt_q > 24'd1) begin
        cnt_d = cnt_q - 24'd1;
      end else begin
        fire = 1'b1;
        if (per_q) cnt_d = load;
        else       state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;

  // Fire beats a same-cycle clear, so set terms are OR-ed in last.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q  <= '0;
      dly_q  <= '0;
      per_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      if (dly_we_i) dly_q <= wdata_i;
      pend_q <= (pend_q & ~clr_pend_i) | fire;
      ovr_q  <= (ovr_q & ~clr_ovr_i) | (fire & pend_q);
    end

  assign dly_o      = dly_q;
  assign armed_o    = (state_q == S_ARMED);
  assign periodic_o = per_q;
  assign pend_o     = pend_q;
  assign ovr_o      = ovr_q;
endmodule

module urv_timer_sched #(
  parameter int g_num_channels = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sys_tick_i,
  urv_timer_sched_if.slave        bus,
  output logic [3:0]              pending_o,
  output logic                    irq_o,
  output logic [1:0]              irq_id_o
);
  localparam int NCH = 4;
  localparam logic [NCH-1:0] IMPL = 4'((1 << g_num_channels) - 1);

  logic                 wr, is_dly, is_ctrl, is_stat, is_mask;
  logic [NCH-1:0][23:0] dly;
  logic [NCH-1:0]       armed, periodic, pend, ovr, pm;
  logic [NCH-1:0]       mask_q;
  logic                 ack_q;
  logic [31:0]          rdata_q, rd_mux;

  assign wr      = bus.req & bus.we;
  assign is_dly  = (bus.addr[3:2] == 2'b00);
  assign is_ctrl = (bus.addr[3:2] == 2'b01);
  assign is_stat = (bus.addr == 4'd8);
  assign is_mask = (bus.addr == 4'd9);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    if (i < g_num_channels) begin : g_impl
      logic sel;
      assign sel = wr && (bus.addr[1:0] == 2'(i));
      urv_timer_chan u_chan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tick_i     (sys_tick_i),
        .dly_we_i   (sel && is_dly),
        .ctrl_we_i  (sel && is_ctrl),
        .wdata_i    (bus.wdata[23:0]),
        .clr_pend_i (wr && is_stat && bus.wdata[i]),
        .clr_ovr_i  (wr && is_stat && bus.wdata[i+4]),
        .dly_o      (dly[i]),
        .armed_o    (armed[i]),
        .periodic_o (periodic[i]),
        .pend_o     (pend[i]),
        .ovr_o      (ovr[i])
      );
    end else begin : g_stub
      assign dly[i]      = '0;
      assign armed[i]    = 1'b0;
      assign periodic[i] = 1'b0;
      assign pend[i]     = 1'b0;
      assign ovr[i]      = 1'b0;
    end
  end

  // Unimplemented channels return zeros from the stubs above.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      4'd0, 4'd1, 4'd2, 4'd3: rd_mux = {8'd0, dly[bus.addr[1:0]]};
      4'd4, 4'd5, 4'd6, 4'd7: rd_mux = {29'd0, pend[bus.addr[1:0]],
                                        periodic[bus.addr[1:0]], armed[bus.addr[1:0]]};
      4'd8:                   rd_mux = {24'd0, ovr, pend};
      4'd9:                   rd_mux = {28'd0, mask_q};
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      mask_q  <= '0;
    end else begin
      ack_q   <= bus.req;
      rdata_q <= (bus.req && !bus.we) ? rd_mux : 32'd0;
      if (wr && is_mask) mask_q <= bus.wdata[3:0] & IMPL;
    end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  assign pm        = pend & mask_q;
  assign pending_o = pend;
  assign irq_o     = |pm;

  // Scan from the top so the lowest index wins.
  always_comb begin
    irq_id_o = 2'd0;
    for (int i = NCH - 1; i >= 0; i--)
      if (pm[i]) irq_id_o = 2'(i);
  end
endmodule

// File: tb/tb_urv_timer_sched.sv
module tb_urv_timer_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] pending;
  logic       irq;
  logic [1:0] irq_id;

  urv_timer_sched_if bus();

  urv_timer_sched #(.g_num_channels(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sys_tick_i (tick),
    .bus        (bus),
    .pending_o  (pending),
    .irq_o      (irq),
    .irq_id_o   (irq_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model (timer semantics, plain arrays) ----------
  logic [23:0] m_dly[4];
  bit          m_arm[4], m_per[4], m_pend[4], m_ovr[4];
  int          m_rem[4];   // ticks still to go before the channel fires
  logic [3:0]  m_mask;

  function automatic void m_reset();
    for (int c = 0; c < 4; c++) begin
      m_dly[c] = '0; m_arm[c] = 0; m_per[c] = 0;
      m_pend[c] = 0; m_ovr[c] = 0; m_rem[c] = 0;
    end
    m_mask = '0;
  endfunction

  function automatic int reload(logic [23:0] v);
    return (v == 24'd0) ? 1 : int'(v);
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] a);
    logic [31:0] v;
    int ch;
    v = '0;
    ch = int'(a[1:0]);
    if (a < 4)       v = {8'h0, m_dly[ch]};
    else if (a < 8)  v = {29'd0, m_pend[ch], m_per[ch], m_arm[ch]};
    else if (a == 8) for (int c = 0; c < 4; c++) begin
                       v[c] = m_pend[c]; v[c+4] = m_ovr[c];
                     end
    else if (a == 9) v = {28'd0, m_mask};
    return v;
  endfunction

  function automatic void m_step(bit r, bit w, logic [3:0] a, logic [31:0] d, bit t);
    bit fire[4];
    bit pold[4];
    int ch;
    ch = int'(a[1:0]);
    for (int c = 0; c < 4; c++) begin
      fire[c] = 0;
      pold[c] = m_pend[c];
      if (t && m_arm[c] && !(r && w && a == 4'(4 + c))) begin
        if (m_rem[c] > 1) m_rem[c]--;
        else begin
          fire[c] = 1;
          if (m_per[c]) m_rem[c] = reload(m_dly[c]);
          else          m_arm[c] = 0;
        end
      end
    end
    if (r && w) begin
      if (a < 4) m_dly[ch] = d[23:0];
      else if (a < 8) begin
        m_arm[ch] = d[0];
        m_per[ch] = d[1];
        if (d[0]) m_rem[ch] = reload(m_dly[ch]);
      end else if (a == 8) begin
        for (int c = 0; c < 4; c++) begin
          if (d[c])   m_pend[c] = 0;
          if (d[c+4]) m_ovr[c]  = 0;
        end
      end else if (a == 9) m_mask = d[3:0];
    end
    for (int c = 0; c < 4; c++)
      if (fire[c]) begin
        if (pold[c]) m_ovr[c] = 1;
        m_pend[c] = 1;
      end
  endfunction

  function automatic logic [3:0] m_pvec();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_pend[c];
    return v;
  endfunction

  function automatic int m_id();
    for (int c = 0; c < 4; c++)
      if (m_pend[c] && m_mask[c]) return c;
    return 0;
  endfunction

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step(input bit r, input bit w, input logic [3:0] a, input logic [31:0] d, input bit t);
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; tick = t;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0; tick = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1, 1, a, d, 0);
  endtask

  task automatic tk(input int n);
    repeat (n) step(0, 0, 4'd0, 32'd0, 1);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    step(1, 0, a, 32'd0, 0);
    chk({nm, "_ack"}, bus.ack, 1);
    chk(nm, bus.rdata, exp);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          req, we;
    logic [3:0]  a;
    logic [31:0] d;
    bit          t;
    logic [31:0] e_rd;
    logic [3:0]  e_pend;
    bit          e_irq;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, bit w, logic [3:0] a, logic [31:0] d, bit t,
                             logic [31:0] erd, logic [3:0] ep, bit ei, logic [1:0] eid);
    vec_t x;
    x.req = r; x.we = w; x.a = a; x.d = d; x.t = t;
    x.e_rd = erd; x.e_pend = ep; x.e_irq = ei; x.e_id = eid;
    return x;
  endfunction

  logic [31:0] exp_rd;
  bit          rr, rw, rt;
  logic [3:0]  ra;
  logic [31:0] rdv;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // reset state, observed while reset is held
    @(posedge clk); #1;
    chk("rst_pending", pending, 0);
    chk("rst_irq", irq, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    m_reset();

    // one-shot channel 0, delay 3, plus register map corners
    tbl.push_back(v(1,1,4'd0, 32'd3,        0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,1,4'd4, 32'd1,        0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,1,4'd9, 32'd1,        0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(0,0,4'd0, 32'd0,        1, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(0,0,4'd0, 32'd0,        1, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(0,0,4'd0, 32'd0,        1, 32'd0, 4'h1, 1, 2'd0));
    tbl.push_back(v(1,0,4'd4, 32'd0,        0, 32'd4, 4'h1, 1, 2'd0));
    tbl.push_back(v(1,0,4'd0, 32'd0,        0, 32'd3, 4'h1, 1, 2'd0));
    tbl.push_back(v(1,0,4'd8, 32'd0,        0, 32'd1, 4'h1, 1, 2'd0));
    tbl.push_back(v(1,1,4'd8, 32'd1,        0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,1,4'd10,32'hFFFF_FFFF,0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,0,4'd10,32'd0,        0, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,1,4'd9, 32'hF,        1, 32'd0, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,0,4'd9, 32'd0,        0, 32'hF, 4'h0, 0, 2'd0));
    tbl.push_back(v(1,0,4'd4, 32'd0,        0, 32'd0, 4'h0, 0, 2'd0));
    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].t);
      chk($sformatf("tbl%0d_ack", i),  bus.ack,   tbl[i].req);
      chk($sformatf("tbl%0d_rd", i),   bus.rdata, tbl[i].e_rd);
      chk($sformatf("tbl%0d_pend", i), pending,   tbl[i].e_pend);
      chk($sformatf("tbl%0d_irq", i),  irq,       tbl[i].e_irq);
      chk($sformatf("tbl%0d_id", i),   irq_id,    tbl[i].e_id);
    end

    // periodic channel 1 with overrun, then W1C
    do_reset();
    wr(4'd1, 32'd2); wr(4'd5, 32'd3);
    tk(1); chk("per_t1", pending, 4'h0);
    tk(1); chk("per_t2", pending, 4'h2);
    tk(2); rd_chk("per_stat", 4'd8, 32'h22);
    wr(4'd8, 32'h22); rd_chk("per_stat_clr", 4'd8, 32'h0);

    // zero delay fires on first tick; arm coincident with tick ignores the tick
    do_reset();
    wr(4'd6, 32'd1);
    tk(1); chk("zd_fire", pending, 4'h4);
    rd_chk("zd_ctrl", 4'd6, 32'h4);
    wr(4'd8, 32'h4); wr(4'd2, 32'd2);
    step(1, 1, 4'd6, 32'd1, 1);
    tk(1); chk("armtick_1", pending, 4'h0);
    tk(1); chk("armtick_2", pending, 4'h4);

    // simultaneous fires and priority
    do_reset();
    wr(4'd1, 32'd2); wr(4'd3, 32'd2); wr(4'd5, 32'd1); wr(4'd7, 32'd1); wr(4'd9, 32'hF);
    tk(2);
    chk("sim_pend", pending, 4'hA); chk("sim_irq", irq, 1); chk("sim_id", irq_id, 1);
    wr(4'd9, 32'h0);
    chk("mask0_irq", irq, 0); chk("mask0_pend", pending, 4'hA); chk("mask0_id", irq_id, 0);
    wr(4'd9, 32'hF); wr(4'd8, 32'h2);
    chk("clr1_id", irq_id, 3); chk("clr1_irq", irq, 1); chk("clr1_pend", pending, 4'h8);

    // fire vs same-cycle W1C; disarm stops further fires
    do_reset();
    wr(4'd0, 32'd1); wr(4'd4, 32'd3); wr(4'd9, 32'd1);
    tk(1); chk("w1c_pre", pending, 4'h1);
    step(1, 1, 4'd8, 32'h1, 1);
    chk("w1c_fire_wins", pending, 4'h1);
    rd_chk("w1c_stat", 4'd8, 32'h11);
    wr(4'd4, 32'd0); wr(4'd8, 32'h11);
    tk(3); chk("disarm_pend", pending, 4'h0); chk("disarm_irq", irq, 0);

    // asynchronous reset while armed, pending, and mid-access
    do_reset();
    wr(4'd0, 32'd1); wr(4'd4, 32'd3); wr(4'd9, 32'd1);
    tk(1); chk("ar_irq_pre", irq, 1);
    rd_chk("ar_ctrl", 4'd4, 32'h7);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 4'd4;
    #2 rst = 1'b1;
    #1;
    chk("ar_pend", pending, 0); chk("ar_irq", irq, 0); chk("ar_id", irq_id, 0);
    chk("ar_ack", bus.ack, 0); chk("ar_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    chk("ar_noack", bus.ack, 0);
    bus.req = 1'b0; rst = 1'b0; m_reset();
    tk(3); chk("ar_nofire", pending, 0);
    rd_chk("ar_ctrl_post", 4'd4, 32'h0);

    // randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rr  = ($urandom_range(0, 1) == 1);
      rw  = ($urandom_range(0, 1) == 1);
      ra  = 4'($urandom_range(0, 11));
      rdv = $urandom;
      rt  = ($urandom_range(0, 2) == 0);
      if (ra < 4) rdv = (rdv & 32'hFF00_0000) | 32'($urandom_range(0, 4));
      exp_rd = (rr && !rw) ? m_read(ra) : 32'd0;
      m_step(rr, rw, ra, rdv, rt);
      step(rr, rw, ra, rdv, rt);
      chk("rnd_ack",   bus.ack,   32'(rr));
      chk("rnd_rdata", bus.rdata, exp_rd);
      chk("rnd_pend",  pending,   m_pvec());
      chk("rnd_irq",   irq,       32'((m_pvec() & m_mask) != 4'h0));
      chk("rnd_id",    irq_id,    32'(m_id()));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
